// File: rtl/pwm_cmd_parser.sv
// pwm_cmd_parser: parses ASCII "DCnn", "P2n" and "P5n" commands into PWM settings and queues 'K'/'E' replies
// ports: rx_data/rx_valid byte strobe in; tx_data/tx_valid/tx_ready reply handshake out;
//        duty_cycle/pow2/pow5 registered settings to pwm_gen; cmd_ok/cmd_err one-cycle result pulses
module pwm_cmd_parser #(
  parameter int DC_INIT = 50,
  parameter int P2_INIT = 0,
  parameter int P5_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] pow2,
  output logic [1:0] pow5,
  output logic [6:0] duty_cycle,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);
  typedef enum logic [3:0] {IDLE, GOT_D, GOT_P, DC_ARG1, DC_ARG2, DC_TERM, PX_ARG, PX_TERM, DISCARD} state_t;
  state_t state, state_nxt;
  logic [6:0] acc, acc_nxt;
  logic       px5;
  logic [1:0] px_val;
  logic       is_t, is_dig, is_px;
  logic       apply_dc, apply_px, err;
  assign is_t   = rx_data == 8'h0D || rx_data == 8'h0A;
  assign is_dig = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_px  = rx_data >= 8'h30 && rx_data <= 8'h33;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (rx_valid) state <= state_nxt;
  // a terminator always closes the line; everything else either advances or falls into DISCARD
  always_comb begin
    state_nxt = DISCARD;
    case (state)
      IDLE:    state_nxt = rx_data == 8'h44 ? GOT_D : rx_data == 8'h50 ? GOT_P : DISCARD;
      GOT_D:   state_nxt = rx_data == 8'h43 ? DC_ARG1 : DISCARD;
      GOT_P:   state_nxt = (rx_data == 8'h32 || rx_data == 8'h35) ? PX_ARG : DISCARD;
      DC_ARG1: state_nxt = is_dig ? DC_ARG2 : DISCARD;
      DC_ARG2: state_nxt = is_dig ? DC_TERM : DISCARD;
      PX_ARG:  state_nxt = is_px ? PX_TERM : DISCARD;
      default: state_nxt = DISCARD;
    endcase
    if (is_t) state_nxt = IDLE;
  end
  // any terminator outside IDLE that does not complete a well-formed command is an error
  always_comb begin
    apply_dc = rx_valid && is_t && (state == DC_ARG2 || state == DC_TERM);
    apply_px = rx_valid && is_t && state == PX_TERM;
    err      = rx_valid && is_t && state != IDLE && !apply_dc && !apply_px;
    acc_nxt  = state == DC_ARG1 ? {3'b0, rx_data[3:0]} : acc * 7'd10 + {3'b0, rx_data[3:0]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty_cycle <= 7'(DC_INIT);
      pow2       <= 2'(P2_INIT);
      pow5       <= 2'(P5_INIT);
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      acc        <= 7'd0;
      px5        <= 1'b0;
      px_val     <= 2'd0;
    end else begin
      cmd_ok  <= apply_dc || apply_px;
      cmd_err <= err;
      if (rx_valid && is_dig && (state == DC_ARG1 || state == DC_ARG2)) acc <= acc_nxt;
      if (rx_valid && state == GOT_P) px5 <= rx_data == 8'h35;
      if (rx_valid && state == PX_ARG) px_val <= rx_data[1:0];
      if (apply_dc) duty_cycle <= acc;
      if (apply_px && !px5) pow2 <= px_val;
      if (apply_px && px5) pow5 <= px_val;
      // a new reply wins over both a pending one and a completing handshake
      if (apply_dc || apply_px || err) begin
        tx_valid <= 1'b1;
        tx_data  <= err ? 8'h45 : 8'h4B;
      end else if (tx_ready) tx_valid <= 1'b0;
    end
endmodule
